// File: rtl/keypad_pkg.sv
// Shared constants, scan-state encoding and the row priority encoder for the
// 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam logic [2:0] LANE_NONE = 3'd4;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    SAMPLE  = 2'd1,
    COMPARE = 2'd2
  } scan_state_e;

  // Lowest-index pressed row wins; LANE_NONE when the column is idle.
  function automatic logic [2:0] row_prio_encode(input logic [3:0] rows);
    logic [2:0] code;
    code = LANE_NONE;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (rows[r]) code = 3'(r);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad lane interface: column strobes and row inputs toward the pad,
// debounced lane codes, press events and scan status toward the game logic.
interface keypad_if;

  logic [3:0] row_in;
  logic [3:0] col_n;
  logic [2:0] num0;
  logic [2:0] num1;
  logic [2:0] num2;
  logic [2:0] num3;
  logic       key_valid;
  logic [3:0] key_code;
  logic       scan_done;
  logic [1:0] scan_state;

  // key_valid is a one-cycle event strobe with no back-pressure: the
  // consumer must take key_code in every cycle key_valid is high.
  modport master (
    input  row_in,
    output col_n, num0, num1, num2, num3,
    output key_valid, key_code, scan_done, scan_state
  );

  modport slave (
    output row_in,
    input  col_n, num0, num1, num2, num3,
    input  key_valid, key_code, scan_done, scan_state
  );

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: strobes columns, samples synchronized rows, debounces
// whole-matrix scans and publishes lane codes plus one event per new press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  keypad_if.master kp
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(DEB_SCANS + 1);
  localparam logic [1:0] ST_SETTLE  = SETTLE;
  localparam logic [1:0] ST_SAMPLE  = SAMPLE;
  localparam logic [1:0] ST_COMPARE = COMPARE;

  logic [3:0]       w_rows;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_col;
  logic [3:0]       r_col_n;
  logic [15:0]      r_snap;
  logic [15:0]      r_prev;
  logic [15:0]      r_deb;
  logic [15:0]      r_pending;
  logic [STB_W-1:0] r_stable;
  logic [2:0]       r_num [NUM_COLS];
  logic [3:0]       r_last_code;

  logic [STB_W-1:0] w_stable_nxt;
  logic             w_deb_load;
  logic [15:0]      w_new_press;
  logic             w_any;
  logic [3:0]       w_low_idx;
  logic [15:0]      w_low_mask;

  sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (kp.row_in),
    .o_q   (w_rows)
  );

  always_comb begin
    w_stable_nxt = STB_W'(1);
    if (r_snap == r_prev) begin
      w_stable_nxt = (r_stable == STB_W'(DEB_SCANS)) ? r_stable : r_stable + 1'b1;
    end
    w_deb_load  = (r_state == ST_COMPARE) && (w_stable_nxt == STB_W'(DEB_SCANS));
    w_new_press = w_deb_load ? (r_snap & ~r_deb) : '0;
  end

  // Scan downward so the lowest set bit is the one left standing.
  always_comb begin
    w_any      = |r_pending;
    w_low_idx  = '0;
    w_low_mask = '0;
    for (int i = 15; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_low_idx     = 4'(i);
        w_low_mask    = '0;
        w_low_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_SETTLE;
      r_cnt    <= '0;
      r_col    <= '0;
      r_col_n  <= 4'b1110;
      r_snap   <= '0;
      r_prev   <= '0;
      r_deb    <= '0;
      r_stable <= '0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          r_snap[{r_col, 2'b00} +: 4] <= w_rows;
          // Strobe moves on the same edge as the index so it stays one-hot-low.
          if (r_col == 2'd3) begin
            r_col   <= '0;
            r_col_n <= 4'b1110;
            r_state <= ST_COMPARE;
          end else begin
            r_col   <= r_col + 1'b1;
            r_col_n <= {r_col_n[2:0], r_col_n[3]};
            r_state <= ST_SETTLE;
          end
        end
        ST_COMPARE: begin
          r_stable <= w_stable_nxt;
          r_prev   <= r_snap;
          if (w_deb_load) r_deb <= r_snap;
          r_state  <= ST_SETTLE;
        end
        default: r_state <= ST_SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_last_code <= '0;
    end else begin
      r_pending <= (r_pending & ~w_low_mask) | w_new_press;
      if (w_any) r_last_code <= w_low_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_COLS; c++) r_num[c] <= LANE_NONE;
    end else begin
      for (int c = 0; c < NUM_COLS; c++) begin
        r_num[c] <= row_prio_encode(r_deb[c*NUM_ROWS +: NUM_ROWS]);
      end
    end
  end

  assign kp.col_n      = r_col_n;
  assign kp.num0       = r_num[0];
  assign kp.num1       = r_num[1];
  assign kp.num2       = r_num[2];
  assign kp.num3       = r_num[3];
  assign kp.key_valid  = w_any;
  assign kp.key_code   = w_any ? w_low_idx : r_last_code;
  assign kp.scan_done  = (r_state == ST_COMPARE);
  assign kp.scan_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEB_SCANS=2 and a
// modelled 4x4 pad that closes row lines under the strobed column.
module tb_keypad_scanner;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_SCANS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  keypad_if kp ();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  logic [15:0] keys = '0;

  always_comb begin
    kp.row_in = '0;
    for (int c = 0; c < 4; c++) begin
      if (!kp.col_n[c]) kp.row_in = kp.row_in | keys[c*4 +: 4];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [3:0] ev_q[$];
  int         ev_t[$];
  logic [3:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && kp.key_valid) begin
      ev_q.push_back(kp.key_code);
      ev_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ev(input string tag);
    check({tag, "_count"}, 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      check({tag, "_code"}, 32'(ev_q[i]), 32'(exp_q[i]));
    end
    ev_q.delete();
    ev_t.delete();
    exp_q.delete();
  endtask

  task automatic check_nums(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                            input logic [2:0] e2, input logic [2:0] e3);
    check({tag, "_num0"}, 32'(kp.num0), 32'(e0));
    check({tag, "_num1"}, 32'(kp.num1), 32'(e1));
    check({tag, "_num2"}, 32'(kp.num2), 32'(e2));
    check({tag, "_num3"}, 32'(kp.num3), 32'(e3));
  endtask

  // Returns at the falling edge inside the n-th COMPARE cycle from now.
  task automatic wait_scans(input int n);
    for (int k = 0; k < n; k++) begin
      bit found;
      found = 1'b0;
      for (int t = 0; t < 100 && !found; t++) begin
        @(negedge clk);
        if (kp.scan_done) found = 1'b1;
      end
      check("scan_done_seen", 32'(found), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_col;
    int p;

    // Reset takes effect before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_col_n", 32'(kp.col_n), 32'h0000_000E);
    check("rst_key_valid", 32'(kp.key_valid), 32'd0);
    check("rst_key_code", 32'(kp.key_code), 32'd0);
    check("rst_scan_done", 32'(kp.scan_done), 32'd0);
    check_nums("rst", 3'd4, 3'd4, 3'd4, 3'd4);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle scanning: two full 21-cycle periods
    for (int i = 0; i < 42; i++) begin
      p = i % 21;
      exp_col = 4'b0001 << (p / 5);
      if (p == 20) exp_col = 4'b0001;
      exp_col = ~exp_col;
      check("idle_col_n", 32'(kp.col_n), 32'(exp_col));
      check("idle_scan_done", 32'(kp.scan_done), (p == 20) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check_nums("idle", 3'd4, 3'd4, 3'd4, 3'd4);
    check_ev("idle_events");

    // Single key (col2,row1)
    wait_scans(1);
    keys = 16'h0200;
    wait_scans(2);
    repeat (2) @(negedge clk);
    check_nums("press9", 3'd4, 3'd4, 3'd1, 3'd4);
    exp_q.push_back(4'h9);
    check_ev("press9_events");
    wait_scans(3);
    check_ev("held_no_repeat");

    // Bounce on (col1,row2) while (col2,row1) stays held
    for (int s = 0; s < 6; s++) begin
      keys = (s % 2 == 0) ? 16'h0240 : 16'h0200;
      wait_scans(1);
    end
    check_ev("bounce_no_event");
    keys = 16'h0240;
    wait_scans(1);
    check_ev("bounce_first_stable");
    wait_scans(1);
    repeat (2) @(negedge clk);
    check_nums("bounce", 3'd4, 3'd2, 3'd1, 3'd4);
    exp_q.push_back(4'h6);
    check_ev("bounce_events");

    // Three simultaneous presses
    wait_scans(1);
    keys = 16'h5248;
    wait_scans(2);
    repeat (4) @(negedge clk);
    check_nums("simul", 3'd3, 3'd2, 3'd1, 3'd0);
    if (ev_t.size() == 3) begin
      check("simul_gap0", 32'(ev_t[1] - ev_t[0]), 32'd1);
      check("simul_gap1", 32'(ev_t[2] - ev_t[1]), 32'd1);
    end
    exp_q.push_back(4'h3);
    exp_q.push_back(4'hC);
    exp_q.push_back(4'hE);
    check_ev("simul_events");

    // Release then re-press (col2,row1)
    wait_scans(1);
    keys = 16'h5048;
    wait_scans(2);
    repeat (2) @(negedge clk);
    check_nums("release9", 3'd3, 3'd2, 3'd4, 3'd0);
    check_ev("release_no_event");
    wait_scans(1);
    keys = 16'h5248;
    wait_scans(2);
    repeat (2) @(negedge clk);
    check_nums("repress9", 3'd3, 3'd2, 3'd1, 3'd0);
    exp_q.push_back(4'h9);
    check_ev("repress_events");

    // Clear the matrix, then press all 16 and reset mid-burst
    wait_scans(1);
    keys = 16'h0000;
    wait_scans(2);
    repeat (2) @(negedge clk);
    check_nums("clear", 3'd4, 3'd4, 3'd4, 3'd4);
    check_ev("clear_no_event");
    wait_scans(1);
    keys = 16'hFFFF;
    wait_scans(2);
    repeat (12) @(negedge clk);
    check("mid_col_n", 32'(kp.col_n), 32'h0000_000B);
    check("mid_pending", 32'(kp.key_valid), 32'd1);
    #1 rst_n = 1'b0;
    keys = 16'h0000;
    #1;
    check("arst_col_n", 32'(kp.col_n), 32'h0000_000E);
    check("arst_key_valid", 32'(kp.key_valid), 32'd0);
    check("arst_key_code", 32'(kp.key_code), 32'd0);
    check("arst_scan_done", 32'(kp.scan_done), 32'd0);
    check_nums("arst", 3'd4, 3'd4, 3'd4, 3'd4);
    for (int i = 0; i < 12; i++) exp_q.push_back(4'(i));
    check_ev("burst_before_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("restart_col_n", 32'(kp.col_n), (i < 5) ? 32'h0000_000E : 32'h0000_000D);
      @(negedge clk);
    end
    wait_scans(3);
    repeat (2) @(negedge clk);
    check_nums("after_reset", 3'd4, 3'd4, 3'd4, 3'd4);
    check_ev("pending_discarded");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
